// File: rtl/dbg_uart_bridge_pkg.sv
// dbg_pkg: shared constants and types for the UART debug bridge.
//   - command opcodes (first byte of every command frame)
//   - response bytes returned on TXD
//   - command FSM state type
package dbg_pkg;

  localparam logic [7:0] OP_HALT   = 8'h01;
  localparam logic [7:0] OP_RUN    = 8'h02;
  localparam logic [7:0] OP_STEP   = 8'h03;
  localparam logic [7:0] OP_RESET  = 8'h04;
  localparam logic [7:0] OP_READ   = 8'h10;
  localparam logic [7:0] OP_WRITE  = 8'h11;
  localparam logic [7:0] OP_STATUS = 8'h20;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_HALTWAIT,
    ST_EXEC,
    ST_ACCESS,
    ST_SEND
  } dbg_state_t;

endpackage

// File: rtl/dbg_uart_bridge_if.sv
// dbg_uart_bridge_if: debug-port bus between the bridge (master) and the core (slave).
//   DBG_HALT_REQ  master->slave  level halt request
//   DBG_HALTED    slave->master  core is stopped
//   DBG_STEP      master->slave  1-cycle single-step pulse
//   DBG_RESET     master->slave  16-cycle core reset
//   DBG_RE/WE     master->slave  access strobes, held until DBG_ACK
//   DBG_ADDR      master->slave  word address, [1:0] always 0
//   DBG_WDATA     master->slave  write data
//   DBG_RDATA     slave->master  read data, valid with DBG_ACK
//   DBG_ACK       slave->master  1-cycle completion pulse
interface dbg_uart_bridge_if;
  logic        DBG_HALT_REQ;
  logic        DBG_HALTED;
  logic        DBG_STEP;
  logic        DBG_RESET;
  logic        DBG_RE;
  logic        DBG_WE;
  logic [31:0] DBG_ADDR;
  logic [31:0] DBG_WDATA;
  logic [31:0] DBG_RDATA;
  logic        DBG_ACK;

  modport master (
    output DBG_HALT_REQ, DBG_STEP, DBG_RESET, DBG_RE, DBG_WE, DBG_ADDR, DBG_WDATA,
    input  DBG_HALTED, DBG_RDATA, DBG_ACK
  );

  modport slave (
    input  DBG_HALT_REQ, DBG_STEP, DBG_RESET, DBG_RE, DBG_WE, DBG_ADDR, DBG_WDATA,
    output DBG_HALTED, DBG_RDATA, DBG_ACK
  );
endinterface

// File: rtl/dbg_uart_bridge_uart_byte.sv
// uart_byte: 8N1 UART receive and transmit bit engines.
//   clk, rst_n  clock, async active-low reset
//   rxd         serial input, idle high (synchronised here)
//   rx_data     last received byte
//   rx_valid    1-cycle pulse, one cycle after a good stop-bit sample
//   txd         serial output, idle high
//   tx_data     byte to send, taken when tx_start && !tx_busy
//   tx_start    load request; the frame starts the following cycle
//   tx_busy     frame in progress; drops during the last stop-bit cycle so a
//               new byte can be loaded with no idle gap on the line
module uart_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       txd,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic          rx_m, rx_s;
  rx_state_t     rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_m     <= rxd;
      rx_s     <= rx_m;
      rx_valid <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt <= HALF_LAST;
            rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rx_s) begin
              rx_cnt  <= BIT_LAST;
              rx_bits <= 3'd7;
              rx_st   <= RX_DATA;
            end else begin
              rx_st <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_cnt <= BIT_LAST;
            if (rx_bits == '0) rx_st <= RX_STOP;
            else rx_bits <= rx_bits - 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            if (rx_s) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              rx_st    <= RX_IDLE;
            end else begin
              rx_st <= RX_BREAK;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        // Framing error: wait for the line to go idle so the low stop bit
        // is not mistaken for a new start edge.
        RX_BREAK: if (rx_s) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  logic [8:0]    tx_sh;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic          tx_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd     <= 1'b1;
      tx_sh   <= '1;
      tx_bits <= '0;
      tx_cnt  <= '0;
      tx_act  <= 1'b0;
      tx_busy <= 1'b0;
    end else if (tx_start && !tx_busy) begin
      txd     <= 1'b0;
      tx_sh   <= {1'b1, tx_data};
      tx_bits <= 4'd9;
      tx_cnt  <= BIT_LAST;
      tx_act  <= 1'b1;
      tx_busy <= 1'b1;
    end else if (tx_act) begin
      if (tx_bits == '0 && tx_cnt == CW'(1)) tx_busy <= 1'b0;
      if (tx_cnt == '0) begin
        tx_cnt <= BIT_LAST;
        if (tx_bits == '0) begin
          tx_act <= 1'b0;
        end else begin
          txd     <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bits <= tx_bits - 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbg_uart_bridge.sv
// dbg_uart_bridge: UART command frames -> mcpu debug-port actions.
//   CLK, RESET_N  clock, async active-low reset
//   RXD, TXD      8N1 UART
//   dbg           debug-port master (halt/step/reset/read/write)
// Build option: DBG_TIMEOUT_EN makes ACCESS give up after TIMEOUT cycles
// without DBG_ACK and answer 0xEE; otherwise ACCESS waits indefinitely.
//
// state    | meaning
// IDLE     | wait for opcode byte
// ARGS     | collect address/data bytes (READ 4, WRITE 8)
// HALTWAIT | DBG_HALT_REQ set, wait for DBG_HALTED
// EXEC     | step pulse or 16-cycle core reset
// ACCESS   | drive RE/WE until DBG_ACK
// SEND     | feed response bytes to the transmitter
module dbg_uart_bridge
  import dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT      = 255
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic RXD,
  output logic TXD,
  dbg_uart_bridge_if.master dbg
);

`ifdef DBG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_start, tx_busy;

  uart_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .rxd      (RXD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .txd      (TXD),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  dbg_state_t  state;
  logic [7:0]  opcode;
  logic [63:0] arg_sh, arg_nxt;
  logic [3:0]  arg_left;
  logic [15:0] idle_cnt;
  logic [3:0]  rst_cnt;
  logic [TW-1:0] to_cnt;
  logic        acc_on;
  logic [39:0] rsp_buf;
  logic [2:0]  rsp_left;

  logic        halt_req_q, step_q, reset_q, re_q, we_q;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;

  // Bytes arrive LSB first, so shift in from the top.
  assign arg_nxt  = {rx_data, arg_sh[63:8]};
  assign tx_start = (state == ST_SEND) && !tx_busy;
  assign tx_data  = rsp_buf[7:0];

  assign dbg.DBG_HALT_REQ = halt_req_q;
  assign dbg.DBG_STEP     = step_q;
  assign dbg.DBG_RESET    = reset_q;
  assign dbg.DBG_RE       = re_q;
  assign dbg.DBG_WE       = we_q;
  assign dbg.DBG_ADDR     = {addr_q, 2'b00};
  assign dbg.DBG_WDATA    = wdata_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      opcode     <= '0;
      arg_sh     <= '0;
      arg_left   <= '0;
      idle_cnt   <= '0;
      rst_cnt    <= '0;
      to_cnt     <= '0;
      acc_on     <= 1'b0;
      rsp_buf    <= '0;
      rsp_left   <= '0;
      halt_req_q <= 1'b0;
      step_q     <= 1'b0;
      reset_q    <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      step_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            opcode <= rx_data;
            case (rx_data)
              OP_HALT: begin
                halt_req_q <= 1'b1;
                state      <= ST_HALTWAIT;
              end
              OP_RUN: begin
                halt_req_q <= 1'b0;
                rsp_buf    <= {32'h0, RSP_ACK};
                rsp_left   <= 3'd1;
                state      <= ST_SEND;
              end
              OP_STEP: state <= ST_EXEC;
              OP_RESET: begin
                reset_q <= 1'b1;
                rst_cnt <= 4'd15;
                state   <= ST_EXEC;
              end
              OP_READ, OP_WRITE: begin
                arg_left <= (rx_data == OP_READ) ? 4'd4 : 4'd8;
                idle_cnt <= 16'hFFFF;
                state    <= ST_ARGS;
              end
              OP_STATUS: begin
                rsp_buf  <= {32'h0, 6'b0, reset_q, dbg.DBG_HALTED};
                rsp_left <= 3'd1;
                state    <= ST_SEND;
              end
              default: begin
                rsp_buf  <= {32'h0, RSP_ERR};
                rsp_left <= 3'd1;
                state    <= ST_SEND;
              end
            endcase
          end
        end
        ST_ARGS: begin
          if (rx_valid) begin
            arg_sh   <= arg_nxt;
            idle_cnt <= 16'hFFFF;
            if (arg_left == 4'd1) begin
              if (opcode == OP_READ) begin
                addr_q <= arg_nxt[63:34];
              end else begin
                addr_q  <= arg_nxt[31:2];
                wdata_q <= arg_nxt[63:32];
              end
              acc_on <= 1'b0;
              state  <= ST_ACCESS;
            end else begin
              arg_left <= arg_left - 1'b1;
            end
          end else if (idle_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        ST_HALTWAIT: begin
          if (dbg.DBG_HALTED) begin
            rsp_buf  <= {32'h0, RSP_ACK};
            rsp_left <= 3'd1;
            state    <= ST_SEND;
          end
        end
        ST_EXEC: begin
          if (opcode == OP_RESET) begin
            if (rst_cnt == '0) begin
              reset_q  <= 1'b0;
              rsp_buf  <= {32'h0, RSP_ACK};
              rsp_left <= 3'd1;
              state    <= ST_SEND;
            end else begin
              rst_cnt <= rst_cnt - 1'b1;
            end
          end else begin
            if (dbg.DBG_HALTED) begin
              step_q  <= 1'b1;
              rsp_buf <= {32'h0, RSP_ACK};
            end else begin
              rsp_buf <= {32'h0, RSP_ERR};
            end
            rsp_left <= 3'd1;
            state    <= ST_SEND;
          end
        end
        ST_ACCESS: begin
          if (!acc_on) begin
            acc_on <= 1'b1;
            re_q   <= (opcode == OP_READ);
            we_q   <= (opcode != OP_READ);
            to_cnt <= TW'(TIMEOUT - 1);
          end else if (dbg.DBG_ACK) begin
            re_q  <= 1'b0;
            we_q  <= 1'b0;
            state <= ST_SEND;
            if (opcode == OP_READ) begin
              rsp_buf  <= {RSP_ACK, dbg.DBG_RDATA};
              rsp_left <= 3'd5;
            end else begin
              rsp_buf  <= {32'h0, RSP_ACK};
              rsp_left <= 3'd1;
            end
          end else if (TO_EN && to_cnt == '0) begin
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            rsp_buf  <= {32'h0, RSP_ERR};
            rsp_left <= 3'd1;
            state    <= ST_SEND;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_start) begin
            rsp_buf  <= {8'h0, rsp_buf[39:8]};
            rsp_left <= rsp_left - 1'b1;
            if (rsp_left == 3'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_uart_bridge.sv
module tb_dbg_uart_bridge;
  localparam int CPB = 16;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic rst_n;
  logic rxd;
  logic txd;

  dbg_uart_bridge_if bus();

  dbg_uart_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT(TO)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .RXD     (rxd),
    .TXD     (txd),
    .dbg     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int tx_frames = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // TX monitor / scoreboard
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge txd);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      check("tx_stop", 64'(txd), 64'd1);
      tx_frames++;
      if (exp_q.size() == 0) check("rsp_pending", 64'(exp_q.size()), 64'd1);
      else check("rsp_byte", 64'(b), 64'(exp_q.pop_front()));
    end
  end

  // Debug-port responder
  logic        resp_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] rdata_val = '0;
  int          acc_cnt = 0, strobe_w = 0, last_strobe_w = 0, wait_ctr = 0;
  logic        in_acc = 1'b0, ack_sent = 1'b0, last_we = 1'b0;
  logic [31:0] last_addr = '0, last_wdata = '0;

  initial begin
    bus.DBG_ACK   = 1'b0;
    bus.DBG_RDATA = '0;
    forever begin
      @(negedge clk);
      bus.DBG_ACK = 1'b0;
      if (ack_sent) begin
        check("strobe_release", 64'({bus.DBG_RE, bus.DBG_WE}), 64'd0);
        ack_sent = 1'b0;
        in_acc   = 1'b0;
      end else if (bus.DBG_RE || bus.DBG_WE) begin
        if (!in_acc) begin
          in_acc     = 1'b1;
          wait_ctr   = 0;
          strobe_w   = 0;
          acc_cnt++;
          last_we    = bus.DBG_WE;
          last_addr  = bus.DBG_ADDR;
          last_wdata = bus.DBG_WDATA;
        end
        strobe_w++;
        if (resp_en && wait_ctr == ack_delay) begin
          bus.DBG_ACK   = 1'b1;
          bus.DBG_RDATA = rdata_val;
          ack_sent      = 1'b1;
        end else begin
          wait_ctr++;
        end
      end else if (in_acc) begin
        in_acc = 1'b0;
        last_strobe_w = strobe_w;
      end
    end
  end

  // Pulse-width monitors
  int step_w = 0, step_pulses = 0, step_last_w = 0;
  int rst_w = 0, rst_pulses = 0, rst_last_w = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.DBG_STEP) step_w++;
      else if (step_w != 0) begin step_pulses++; step_last_w = step_w; step_w = 0; end
      if (bus.DBG_RESET) rst_w++;
      else if (rst_w != 0) begin rst_pulses++; rst_last_w = rst_w; rst_w = 0; end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rsp(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("rsp_drain", 64'(exp_q.size()), 64'd0);
    repeat (CPB * 2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txd"}, 64'(txd), 64'd1);
    check({tag, "_halt_req"}, 64'(bus.DBG_HALT_REQ), 64'd0);
    check({tag, "_step"}, 64'(bus.DBG_STEP), 64'd0);
    check({tag, "_reset"}, 64'(bus.DBG_RESET), 64'd0);
    check({tag, "_strobes"}, 64'({bus.DBG_RE, bus.DBG_WE}), 64'd0);
    check({tag, "_addr"}, 64'(bus.DBG_ADDR), 64'd0);
    check({tag, "_wdata"}, 64'(bus.DBG_WDATA), 64'd0);
  endtask

  initial begin
    int p0, f0, a0;
    rxd = 1'b1;
    rst_n = 1'b0;
    bus.DBG_HALTED = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // STATUS from reset
    exp_q.push_back(8'h00);
    send_byte(8'h20);
    wait_rsp(2000);

    // HALT, core stops 20 cycles later
    exp_q.push_back(8'hA5);
    f0 = tx_frames;
    send_byte(8'h01);
    repeat (4) @(negedge clk);
    check("halt_req_set", 64'(bus.DBG_HALT_REQ), 64'd1);
    repeat (16) @(negedge clk);
    check("halt_no_early_ack", 64'(tx_frames - f0), 64'd0);
    check("halt_txd_idle", 64'(txd), 64'd1);
    bus.DBG_HALTED = 1'b1;
    wait_rsp(2000);

    exp_q.push_back(8'h01);
    send_byte(8'h20);
    wait_rsp(2000);

    // STEP while halted
    p0 = step_pulses;
    exp_q.push_back(8'hA5);
    send_byte(8'h03);
    wait_rsp(2000);
    check("step_pulses", 64'(step_pulses - p0), 64'd1);
    check("step_width", 64'(step_last_w), 64'd1);

    // RESET keeps halt request
    p0 = rst_pulses;
    exp_q.push_back(8'hA5);
    send_byte(8'h04);
    wait_rsp(2000);
    check("reset_pulses", 64'(rst_pulses - p0), 64'd1);
    check("reset_width", 64'(rst_last_w), 64'd16);
    check("reset_keeps_halt", 64'(bus.DBG_HALT_REQ), 64'd1);

    // RUN
    exp_q.push_back(8'hA5);
    send_byte(8'h02);
    wait_rsp(2000);
    check("run_halt_req", 64'(bus.DBG_HALT_REQ), 64'd0);
    bus.DBG_HALTED = 1'b0;

    // STEP while running
    p0 = step_pulses;
    exp_q.push_back(8'hEE);
    send_byte(8'h03);
    wait_rsp(2000);
    check("step_running_no_pulse", 64'(step_pulses - p0), 64'd0);

    // WRITE 0xDEADBEEF to 0x10
    a0 = acc_cnt;
    ack_delay = 3;
    exp_q.push_back(8'hA5);
    send_byte(8'h11);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_rsp(2000);
    check("wr_count", 64'(acc_cnt - a0), 64'd1);
    check("wr_is_we", 64'(last_we), 64'd1);
    check("wr_addr", 64'(last_addr), 64'h10);
    check("wr_wdata", 64'(last_wdata), 64'hDEADBEEF);

    // READ from 0x13 (low bits forced off), ack on the first strobe cycle
    a0 = acc_cnt;
    ack_delay = 0;
    rdata_val = 32'h12345678;
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'hA5);
    send_byte(8'h10);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_rsp(3000);
    check("rd_count", 64'(acc_cnt - a0), 64'd1);
    check("rd_is_re", 64'(last_we), 64'd0);
    check("rd_addr", 64'(last_addr), 64'h10);

    // Unknown opcode
    exp_q.push_back(8'hEE);
    send_byte(8'h7F);
    wait_rsp(2000);

    // Framing error is dropped silently
    f0 = tx_frames;
    send_byte(8'h7F, 1'b0);
    repeat (CPB * 24) @(negedge clk);
    check("bad_stop_no_rsp", 64'(tx_frames - f0), 64'd0);
    exp_q.push_back(8'h00);
    send_byte(8'h20);
    wait_rsp(2000);

`ifdef DBG_TIMEOUT_EN
    resp_en = 1'b0;
    exp_q.push_back(8'hEE);
    send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_rsp(4000);
    check("timeout_strobe_width", 64'(last_strobe_w), 64'(TO));
    resp_en = 1'b1;
`endif

    // Reset in the middle of a WRITE
    exp_q.push_back(8'hA5);
    send_byte(8'h01);
    bus.DBG_HALTED = 1'b1;
    wait_rsp(2000);
    f0 = tx_frames;
    send_byte(8'h11);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midcmd");
    bus.DBG_HALTED = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB * 24) @(negedge clk);
    check("midcmd_no_rsp", 64'(tx_frames - f0), 64'd0);
    exp_q.push_back(8'h00);
    send_byte(8'h20);
    wait_rsp(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
